demux_1_32_sequencer: RTL and testbench

Upstream driver for the 1:32 demultiplexer. It accepts a 32-bit word plus a 32-bit channel mask over a valid/ready handshake. It then walks the enabled channels in ascending index order, holding each for a programmable number of cycles, and presents Enable/Data/Select so that each channel receives its bit. A one-cycle done pulse marks the end of each word; between words Enable is low, so the demultiplexer outputs float.

---
 rtl/demux_1_32_sequencer_if.sv | 23 ++
 rtl/demux_1_32_sequencer.sv | 136 +++++++++++++
 tb/tb_demux_1_32_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_32_sequencer_if.sv
// Word handshake and demultiplexer drive bundle for demux_1_32_sequencer.
// The master side is the upstream word source. The slave side is the sequencer.
interface demux_1_32_sequencer_if;
    logic        Word_Valid_In;
    logic [31:0] Word_Data_In;
    logic [31:0] Channel_Mask_In;
    logic        Word_Ready_Out;
    logic        Enable_Out;
    logic        Data_Out;
    logic [4:0]  Select_Out;
    logic        Busy_Out;
    logic        Done_Out;

    modport master (
        output Word_Valid_In, Word_Data_In, Channel_Mask_In,
        input  Word_Ready_Out, Enable_Out, Data_Out, Select_Out, Busy_Out, Done_Out
    );

    modport slave (
        input  Word_Valid_In, Word_Data_In, Channel_Mask_In,
        output Word_Ready_Out, Enable_Out, Data_Out, Select_Out, Busy_Out, Done_Out
    );
endinterface

// File: rtl/demux_1_32_sequencer.sv
// Walks the set bits of a captured channel mask in ascending order. Each channel's
// word bit is presented on Enable/Data/Select for HOLD_CYCLES cycles, then Done pulses.
module demux_1_32_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic Clk_In,
    input  logic Reset_n_In,
    demux_1_32_sequencer_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 32'd1);

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] mask_q, mask_d;
    logic [4:0]  sel_q, sel_d;
    logic [7:0]  hold_q, hold_d;
    logic        enable_q, enable_d;
    logic        data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] above_mask;
    logic [5:0]  first_hit;
    logic [5:0]  next_hit;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [5:0] first_set(input logic [31:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 5'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        enable_d = enable_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // At sel_q=31 the shifted term wraps to 0, so nothing lies above it.
        above_mask = mask_q & ~((32'd2 << sel_q) - 32'd1);
        next_hit   = first_set(above_mask);
        first_hit  = first_set(bus.Channel_Mask_In);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Word_Valid_In) begin
                    word_d = bus.Word_Data_In;
                    mask_d = bus.Channel_Mask_In;
                    busy_d = 1'b1;
                    if (first_hit[5]) begin
                        state_d  = ST_DRIVE;
                        sel_d    = first_hit[4:0];
                        hold_d   = HOLD_RELOAD;
                        enable_d = 1'b1;
                        data_d   = bus.Word_Data_In[first_hit[4:0]];
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (next_hit[5]) begin
                    sel_d  = next_hit[4:0];
                    hold_d = HOLD_RELOAD;
                    data_d = word_q[next_hit[4:0]];
                end else begin
                    state_d  = ST_DONE;
                    sel_d    = 5'd0;
                    hold_d   = 8'd0;
                    enable_d = 1'b0;
                    data_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                sel_d    = 5'd0;
                enable_d = 1'b0;
                data_d   = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                sel_d    = 5'd0;
                hold_d   = 8'd0;
                enable_d = 1'b0;
                data_d   = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            hold_q   <= '0;
            enable_q <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Word_Ready_Out = (state_q == ST_IDLE);
    assign bus.Enable_Out     = enable_q;
    assign bus.Data_Out       = data_q;
    assign bus.Select_Out     = sel_q;
    assign bus.Busy_Out       = busy_q;
    assign bus.Done_Out       = done_q;
endmodule

// File: tb/tb_demux_1_32_sequencer.sv
// Bench for demux_1_32_sequencer: two instances (HOLD_CYCLES 1 and 3) checked against a
// per-cycle trace model built from the mask bits, plus table vectors and reset sequences.
module tb_demux_1_32_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1_32_sequencer_if if_h1 ();
    demux_1_32_sequencer_if if_h3 ();

    demux_1_32_sequencer #(.HOLD_CYCLES(1)) u_dut_h1 (.Clk_In(clk), .Reset_n_In(rst_n), .bus(if_h1.slave));
    demux_1_32_sequencer #(.HOLD_CYCLES(3)) u_dut_h3 (.Clk_In(clk), .Reset_n_In(rst_n), .bus(if_h3.slave));

    typedef struct packed {
        logic       rdy;
        logic       en;
        logic       dat;
        logic [4:0] sel;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int          d;
        logic [31:0] w;
        logic [31:0] m;
        int          done_at;
        int          first_sel;
        int          last_sel;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t trace[$];
    int   done_at;
    obs_t idle_o;
    obs_t none_o;

    function automatic obs_t mk(input logic rdy, input logic en, input logic dat,
                                input logic [4:0] sel, input logic busy, input logic done);
        obs_t o;
        o.rdy = rdy; o.en = en; o.dat = dat; o.sel = sel; o.busy = busy; o.done = done;
        return o;
    endfunction

    function automatic obs_t sample(input int d);
        if (d == 0)
            return mk(if_h1.Word_Ready_Out, if_h1.Enable_Out, if_h1.Data_Out,
                      if_h1.Select_Out, if_h1.Busy_Out, if_h1.Done_Out);
        return mk(if_h3.Word_Ready_Out, if_h3.Enable_Out, if_h3.Data_Out,
                  if_h3.Select_Out, if_h3.Busy_Out, if_h3.Done_Out);
    endfunction

    function automatic int hold_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] w, input logic [31:0] m);
        if (d == 0) begin
            if_h1.Word_Valid_In = v; if_h1.Word_Data_In = w; if_h1.Channel_Mask_In = m;
        end else begin
            if_h3.Word_Valid_In = v; if_h3.Word_Data_In = w; if_h3.Channel_Mask_In = m;
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rdy=%b en=%b dat=%b sel=%0d busy=%b done=%b, need rdy=%b en=%b dat=%b sel=%0d busy=%b done=%b",
                     name, act.rdy, act.en, act.dat, act.sel, act.busy, act.done,
                     exp.rdy, exp.en, exp.dat, exp.sel, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    // Expected cycles after the handshake: H cycles per set bit, low to high, then DONE, then IDLE.
    task automatic build_exp(input logic [31:0] w, input logic [31:0] m, input int h);
        exp_q.delete();
        for (int i = 0; i < 32; i++)
            if (m[i])
                for (int r = 0; r < h; r++)
                    exp_q.push_back(mk(1'b0, 1'b1, w[i], 5'(i), 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
        exp_q.push_back(idle_o);
    endtask

    // Call just after the handshake edge; ends at the negedge of the first IDLE cycle.
    task automatic check_trace(input int d, input logic [31:0] w, input logic [31:0] m, input string name);
        obs_t o;
        build_exp(w, m, hold_of(d));
        trace.delete();
        done_at = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            o = sample(d);
            trace.push_back(o);
            if (o.done && done_at < 0) done_at = k + 1;
            check_obs($sformatf("%s_t%0d", name, k + 1), o, exp_q[k]);
        end
    endtask

    task automatic run_word(input int d, input logic [31:0] w, input logic [31:0] m, input string name);
        check_obs({name, "_pre"}, sample(d), idle_o);
        drive(d, 1'b1, w, m);
        @(posedge clk);
        #1 drive(d, 1'b0, $urandom, $urandom);
        check_trace(d, w, m, name);
    endtask

    vec_t        tbl[6];
    int          sparse_sel[9];
    int          sparse_dat[9];
    int          fsel, lsel, d;
    logic [31:0] w, m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_o = mk(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        none_o = idle_o;
        tbl[0] = '{0, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 33, 0, 31};
        tbl[1] = '{1, 32'h8000_0001, 32'h8000_0011, 10, 0, 31};
        tbl[2] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1, -1, -1};
        tbl[3] = '{0, 32'h1234_5678, 32'h0000_0003, 3, 0, 1};
        tbl[4] = '{1, 32'hDEAD_BEEF, 32'h8000_0000, 4, 31, 31};
        tbl[5] = '{1, 32'h0F0F_0F0F, 32'h0001_0100, 7, 8, 16};
        sparse_sel = '{0, 0, 0, 4, 4, 4, 31, 31, 31};
        sparse_dat = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);

        // Reset state, then a quiet idle period.
        @(negedge clk);
        check_obs("rst_h1", sample(0), none_o);
        check_obs("rst_h3", sample(1), none_o);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_obs($sformatf("idle_h1_%0d", i), sample(0), idle_o);
            check_obs($sformatf("idle_h3_%0d", i), sample(1), idle_o);
        end

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            run_word(tbl[i].d, tbl[i].w, tbl[i].m, $sformatf("vec%0d", i));
            check_int($sformatf("vec%0d_done_at", i), done_at, tbl[i].done_at);
            fsel = -1; lsel = -1;
            foreach (trace[k])
                if (trace[k].en) begin
                    if (fsel < 0) fsel = int'(trace[k].sel);
                    lsel = int'(trace[k].sel);
                end
            check_int($sformatf("vec%0d_first_sel", i), fsel, tbl[i].first_sel);
            check_int($sformatf("vec%0d_last_sel", i), lsel, tbl[i].last_sel);
            if (i == 1)
                for (int k = 0; k < 9; k++) begin
                    check_int($sformatf("sparse_sel%0d", k), int'(trace[k].sel), sparse_sel[k]);
                    check_int($sformatf("sparse_dat%0d", k), int'(trace[k].dat), sparse_dat[k]);
                end
        end

        // Back-to-back: Valid stays high and the data changes during the first word.
        drive(0, 1'b1, 32'h0000_0001, 32'h3);
        @(posedge clk);
        #1 drive(0, 1'b1, 32'h0000_0002, 32'h3);
        check_trace(0, 32'h0000_0001, 32'h3, "b2b_a");
        @(posedge clk);
        #1 drive(0, 1'b0, $urandom, $urandom);
        check_trace(0, 32'h0000_0002, 32'h3, "b2b_b");

        // Reset mid-word at cycle t0+10.
        w = $urandom;
        drive(0, 1'b1, w, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 drive(0, 1'b0, $urandom, $urandom);
        repeat (10) @(negedge clk);
        check_obs("midrst_before", sample(0), mk(1'b0, 1'b1, w[9], 5'd9, 1'b1, 1'b0));
        #1 rst_n = 1'b0;
        #1 check_obs("midrst_async", sample(0), none_o);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_obs($sformatf("midrst_nodone%0d", i), sample(0), idle_o);
        end
        run_word(0, 32'h0000_0001, 32'h1, "post_rst");

        // Randomized words against the trace model.
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 1));
            w = $urandom;
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = 32'd1 << $urandom_range(0, 31);
                2: m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            run_word(d, w, m, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
